// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC byte-fetch controller.
//   fetch_state_t : controller states IDLE / INIT / RUN / FETCH
//   bn_t          : signed 4-bit bits-needed counter value
//   BN_RESET_C    : counter value after reset or slice start
package cabac_pkg;

  typedef enum logic [1:0] {IDLE, INIT, RUN, FETCH} fetch_state_t;

  typedef logic signed [3:0] bn_t;

  localparam bn_t BN_RESET_C = bn_t'(-8);

endpackage

// File: rtl/cabac_byte_fetch_ctrl_bits_needed.sv
// bitsNeeded datapath: combinational counter update for one decode step.
// Ports:
//   bn_in        : current signed counter
//   num_bits     : regular-path renorm shift amount
//   nbin         : bypass bin count minus 1
//   bypass       : 1 = bypass command
//   mps_lps      : path select (0 with mps_renorm=1 holds the counter)
//   mps_renorm   : renorm flag
//   bn_out       : next counter value
//   sum          : pre-wrap sum, used for value alignment
//   request_byte : a new bitstream byte is needed
module cabac_byte_fetch_ctrl_bits_needed
  import cabac_pkg::*;
(
  input  bn_t        bn_in,
  input  logic [2:0] num_bits,
  input  logic [1:0] nbin,
  input  logic       bypass,
  input  logic       mps_lps,
  input  logic       mps_renorm,
  output bn_t        bn_out,
  output bn_t        sum,
  output logic       request_byte
);

  logic [2:0] addend;
  logic       hold;

  always_comb begin
    addend       = bypass ? ({1'b0, nbin} + 3'd1) : num_bits;
    sum          = bn_in + bn_t'({1'b0, addend});
    hold         = !bypass && !mps_lps && mps_renorm;
    request_byte = !sum[3] && !hold;
    // sum in 0..7 wraps to sum-8, i.e. just set the sign bit
    if (hold)
      bn_out = bn_in;
    else if (sum[3])
      bn_out = sum;
    else
      bn_out = {1'b1, sum[2:0]};
  end

endmodule

// File: rtl/cabac_byte_fetch_ctrl.sv
// CABAC byte-fetch controller: owns the bits-needed counter, accepts
// decode-step commands and stalls for bitstream bytes when the counter
// wraps. Also performs the slice-start initial byte load.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin slice / reinitialise (highest priority)
//   cmd_*                 : decode-step command handshake and fields
//   byte_valid/ready/in   : bitstream byte handshake
//   byte_load/out/init    : value-register byte shift pulse, data, init flag
//   bits_needed, shift_rb : registered counter and pre-wrap sum
//   init_done, busy       : initial load finished, not in RUN
//   byte_count            : saturating byte counter (CABAC_BYTE_FETCH_COUNT_EN)
module cabac_byte_fetch_ctrl
  import cabac_pkg::*;
#(
  parameter int unsigned INIT_BYTES = 2,
  parameter bn_t         BN_RESET   = BN_RESET_C
`ifdef CABAC_BYTE_FETCH_COUNT_EN
  ,
  parameter int unsigned COUNT_W    = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_num_bits,
  input  logic [1:0]         cmd_nbin,
  input  logic               cmd_bypass,
  input  logic               cmd_mps_lps,
  input  logic               cmd_mps_renorm,
  input  logic               byte_valid,
  output logic               byte_ready,
  input  logic [7:0]         byte_in,
  output logic               byte_load,
  output logic [7:0]         byte_out,
  output logic               byte_init,
  output logic signed [3:0]  bits_needed,
  output logic signed [3:0]  shift_rb,
  output logic               init_done,
`ifdef CABAC_BYTE_FETCH_COUNT_EN
  output logic [COUNT_W-1:0] byte_count,
`endif
  output logic               busy
);

  fetch_state_t state, state_d;
  logic [7:0]   init_cnt;
  logic         cmd_hs, byte_hs, init_last;
  bn_t          bn_next, sum;
  logic         request_byte;

  cabac_byte_fetch_ctrl_bits_needed u_bits_needed (
    .bn_in        (bits_needed),
    .num_bits     (cmd_num_bits),
    .nbin         (cmd_nbin),
    .bypass       (cmd_bypass),
    .mps_lps      (cmd_mps_lps),
    .mps_renorm   (cmd_mps_renorm),
    .bn_out       (bn_next),
    .sum          (sum),
    .request_byte (request_byte)
  );

  // start masks both handshakes so nothing is consumed in a restart cycle
  always_comb begin
    cmd_ready  = (state == RUN) && !start;
    byte_ready = ((state == INIT) || (state == FETCH)) && !start;
    cmd_hs     = cmd_valid && cmd_ready;
    byte_hs    = byte_valid && byte_ready;
    init_last  = (state == INIT) && (init_cnt == 8'(INIT_BYTES - 1));
    busy       = (state != RUN);
  end

  always_comb begin
    state_d = state;
    if (start) begin
      state_d = INIT;
    end else begin
      case (state)
        IDLE:    state_d = IDLE;
        INIT:    if (byte_hs && init_last) state_d = RUN;
        RUN:     if (cmd_hs && request_byte) state_d = FETCH;
        FETCH:   if (byte_hs) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_needed <= BN_RESET;
      shift_rb    <= '0;
      byte_out    <= '0;
      byte_load   <= 1'b0;
      byte_init   <= 1'b0;
      init_done   <= 1'b0;
      init_cnt    <= '0;
    end else begin
      byte_load <= byte_hs;
      byte_init <= byte_hs && (state == INIT);
      if (byte_hs) byte_out <= byte_in;
      if (start) begin
        bits_needed <= BN_RESET;
        init_cnt    <= '0;
        init_done   <= 1'b0;
      end else begin
        if (byte_hs && (state == INIT)) begin
          init_cnt <= init_cnt + 8'd1;
          if (init_last) init_done <= 1'b1;
        end
        if (cmd_hs) begin
          bits_needed <= bn_next;
          shift_rb    <= sum;
        end
      end
    end
  end

`ifdef CABAC_BYTE_FETCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           byte_count <= '0;
    else if (start)                       byte_count <= '0;
    else if (byte_hs && byte_count != '1) byte_count <= byte_count + 1'b1;
  end
`endif

endmodule

// File: doc/cabac_byte_fetch_ctrl.md
Name: cabac_byte_fetch_ctrl

Overview:
Sequencer that owns the signed bits-needed counter of the VVC CABAC arithmetic decoder and feeds bytes from the bitstream into the value register.
- Accepts one decode-step command per handshake: regular bin, bypass bins or renormalisation.
- Updates the counter through the bitsNeeded datapath.
- When that datapath raises request_byte, stalls the decode engine until one bitstream byte has been fetched.
- Also performs the slice-start initial byte load.

Parameters:
INIT_BYTES, 2, number of bytes loaded into the value register after start.
BN_RESET, -8, signed 4-bit counter value after reset or start.
COUNT_W, 16, width of the optional byte counter.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin slice, reinitialise
cmd_valid  input  1  decode-step command valid
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
cmd_num_bits  input  3  renorm shift amount (regular path)
cmd_nbin  input  2  bypass bin count minus 1
cmd_bypass  input  1  1 = bypass command
cmd_mps_lps  input  1  path select, datapath encoding
cmd_mps_renorm  input  1  renorm flag, datapath encoding
byte_valid  input  1  bitstream byte available
byte_ready  output  1  controller takes byte
byte_in  input  8  bitstream byte
byte_load  output  1  one-cycle pulse: shift byte_out into value register
byte_out  output  8  registered copy of accepted byte
byte_init  output  1  qualifies byte_load as initial load
bits_needed  output  4  signed current counter (registered)
shift_rb  output  4  signed pre-wrap sum of last accepted command, for value alignment
init_done  output  1  high once initial load complete
busy  output  1  high in any state other than RUN

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE; bits_needed=BN_RESET; shift_rb=0.
  - byte_out=0; byte_load=0; byte_init=0; init_done=0.
  - cmd_ready=0; byte_ready=0; busy=1.
- States:
  - IDLE: wait for start.
  - INIT: byte_ready=1; count INIT_BYTES byte handshakes.
  - RUN: cmd_ready=1.
  - FETCH: byte_ready=1, cmd_ready=0.
- IDLE --start--> INIT. bits_needed=BN_RESET, init counter=0, init_done=0.
- INIT: each byte_valid&byte_ready registers byte_in into byte_out and pulses byte_load with byte_init=1 in the next cycle. After INIT_BYTES bytes → RUN and init_done=1. bits_needed stays BN_RESET.
- RUN, command handshake: combinational bitsNeeded update on current bits_needed.
  - Addend: cmd_bypass ? cmd_nbin+1 : cmd_num_bits.
  - Sum: 4-bit signed; shift_rb<=sum.
  - If sum>=0, wrapped value = sum-8; otherwise wrapped value = sum.
  - Bypass: bits_needed<=wrapped.
  - Regular: bits_needed<=wrapped unless (cmd_mps_lps=0 & cmd_mps_renorm=1), in which case it holds.
  - request_byte = comp (sum>=0), gated to 0 when regular and held.
  - request_byte=1 → next state FETCH; else stay RUN, back-to-back commands allowed every cycle.
- FETCH: on byte handshake, byte_out<=byte_in, byte_load pulses next cycle (byte_init=0) → RUN. Minimum stall is one cycle; byte_valid low extends the stall indefinitely.
- Latency:
  - bits_needed and shift_rb are valid the cycle after the command handshake.
  - byte_load rises the cycle after the byte handshake.
- Simultaneous events and boundaries:
  - start has priority over everything in every state, including mid-FETCH or mid-INIT. Any pending byte handshake in that cycle is ignored: byte_ready is forced 0 while start=1.
  - cmd_valid in INIT/FETCH/IDLE is not accepted.
  - cmd_nbin=3 with bits_needed=-1 gives sum 3 → wrapped -5, request.
  - Precondition: upstream guarantees bits_needed+addend <= 7; there is no overflow detection.
- busy=(state!=RUN).

Optional Feature:
CABAC_BYTE_FETCH_COUNT_EN
- With the macro: adds output byte_count [COUNT_W-1:0].
  - Increments on every byte handshake (INIT and FETCH) and saturates at all-ones.
  - Cleared by reset and by start.
- Without the macro: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cabac_pkg holds:
  - state enum fetch_state_t {IDLE, INIT, RUN, FETCH};
  - constant BN_RESET_C=-8;
  - typedef bn_t (signed 4-bit).
- Instantiate the existing bitsNeeded module as the single sub-module for the arithmetic. The controller adds only the register, FSM and handshakes.

Test Plan:
- Reset then start, byte_valid with a 2-cycle gap between 0xA5 and 0x3C → two byte_load pulses with byte_init=1 carrying 0xA5, 0x3C; init_done=1; bits_needed=-8.
- RUN, regular cmd num_bits=3, mps_lps=1 from -8 → bits_needed=-5, shift_rb=-5, no FETCH, next cmd accepted in the following cycle.
- From -3, regular num_bits=5, mps_lps=1 → shift_rb=2, bits_needed=-6, FETCH entered; byte 0x7E after 3 cycles → byte_load with byte_out=0x7E, byte_init=0, return to RUN.
- From -2, bypass nbin=3 → sum 2, bits_needed=-6, FETCH. Then regular mps_lps=0, mps_renorm=1, num_bits=7 from -6 → bits_needed stays -6, no FETCH.
- start asserted in FETCH while byte_valid=1 → no byte_load for that byte, state INIT, bits_needed=-8, init_done=0.
- With CABAC_BYTE_FETCH_COUNT_EN, COUNT_W=2, fetch 5 bytes → byte_count=3 (saturated); start clears to 0.
